// File: rtl/baser_test_sequencer.sv
// BASE-R test sequencer: runs a settle / DATA / CTRL / RAND / drain sequence on
// the pattern generator, snapshots the checker counters at traffic start and
// grades the run from the counter deltas.
module baser_test_sequencer #(
  parameter int SETTLE_LEN = 4,
  parameter int PHASE_LEN  = 16,
  parameter int DRAIN_LEN  = 8
) (
  input  logic        clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [31:0] i_block_count,
  input  logic [31:0] i_data_count,
  input  logic [31:0] i_ctrl_count,
  input  logic [31:0] i_inv_block_count,
  output logic        o_enable,
  output logic [2:0]  o_valid,
  output logic [3:0]  o_data_sel_0,
  output logic        o_random_0,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_pass,
  output logic [2:0]  o_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_DATA   = 3'd2,
    S_CTRL   = 3'd3,
    S_RAND   = 3'd4,
    S_DRAIN  = 3'd5,
    S_CHECK  = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] blk_snap_q, data_snap_q, ctrl_snap_q, inv_snap_q;
  logic        enable_q, random_q, busy_q, done_q, pass_q;
  logic [2:0]  valid_q;
  logic [3:0]  sel_q;

  // Counter value loaded on entry: the state then lasts (value + 1) cycles.
  function automatic logic [31:0] reload(input state_t s);
    case (s)
      S_SETTLE:                reload = 32'(SETTLE_LEN - 1);
      S_DATA, S_CTRL, S_RAND:  reload = 32'(PHASE_LEN - 1);
      S_DRAIN:                 reload = 32'(DRAIN_LEN - 1);
      default:                 reload = 32'd0;
    endcase
  endfunction

  // Deltas are modulo 2^32 so a counter that wrapped still yields the true delta.
  logic [31:0] blk_dlt, data_dlt, ctrl_dlt, inv_dlt, dc_sum;
  logic        pass_c;
  assign blk_dlt  = i_block_count     - blk_snap_q;
  assign data_dlt = i_data_count      - data_snap_q;
  assign ctrl_dlt = i_ctrl_count      - ctrl_snap_q;
  assign inv_dlt  = i_inv_block_count - inv_snap_q;
  assign dc_sum   = data_dlt + ctrl_dlt;
  assign pass_c   = (inv_dlt == 32'd0) && (data_dlt != 32'd0) &&
                    (ctrl_dlt != 32'd0) && (blk_dlt == dc_sum);

  // Next state and counter; abort wins over start and over counter expiry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          state_d = S_SETTLE;
          cnt_d   = reload(S_SETTLE);
        end
      end
      default: begin
        if (i_abort) begin
          state_d = S_IDLE;
          cnt_d   = 32'd0;
        end else if (cnt_q == 32'd0) begin
          state_d = state_t'(state_q + 3'd1);
          cnt_d   = reload(state_t'(state_q + 3'd1));
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
    endcase
  end

  // State, snapshots and registered outputs, all decoded from the next state.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 32'd0;
      blk_snap_q  <= 32'd0;
      data_snap_q <= 32'd0;
      ctrl_snap_q <= 32'd0;
      inv_snap_q  <= 32'd0;
      enable_q    <= 1'b0;
      valid_q     <= 3'b000;
      sel_q       <= 4'b0000;
      random_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      enable_q <= (state_d == S_DATA) || (state_d == S_CTRL) || (state_d == S_RAND);
      valid_q  <= ((state_d == S_DATA) || (state_d == S_CTRL) || (state_d == S_RAND)) ?
                  3'b111 : 3'b000;
      sel_q    <= (state_d == S_DATA) ? 4'b0001 : 4'b0000;
      random_q <= (state_d == S_RAND);
      busy_q   <= (state_d != S_IDLE) && (state_d != S_DONE);
      done_q   <= (state_d == S_DONE);
      if (state_q == S_SETTLE && state_d == S_DATA) begin
        blk_snap_q  <= i_block_count;
        data_snap_q <= i_data_count;
        ctrl_snap_q <= i_ctrl_count;
        inv_snap_q  <= i_inv_block_count;
      end
      if (state_q == S_CHECK && state_d == S_DONE) pass_q <= pass_c;
      else if (state_d != S_DONE)                  pass_q <= 1'b0;
    end
  end

  assign o_enable     = enable_q;
  assign o_valid      = valid_q;
  assign o_data_sel_0 = sel_q;
  assign o_random_0   = random_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_pass       = pass_q;
  assign o_state      = state_q;

endmodule

// File: tb/tb_baser_test_sequencer.sv
// Bench for baser_test_sequencer: expected per-cycle output words are queued
// when a run is started and popped/compared as the DUT steps through it.
module tb_baser_test_sequencer;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1, i_start = 1'b0, i_abort = 1'b0;
  logic [31:0] i_block_count = '0, i_data_count = '0, i_ctrl_count = '0, i_inv_block_count = '0;
  logic        o_enable, o_random_0, o_busy, o_done, o_pass;
  logic [2:0]  o_valid, o_state;
  logic [3:0]  o_data_sel_0;

  int total = 0;
  int bad   = 0;
  logic [14:0] sb[$];

  baser_test_sequencer #(.SETTLE_LEN(4), .PHASE_LEN(16), .DRAIN_LEN(8)) dut (
    .clk(clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
    .i_block_count(i_block_count), .i_data_count(i_data_count),
    .i_ctrl_count(i_ctrl_count), .i_inv_block_count(i_inv_block_count),
    .o_enable(o_enable), .o_valid(o_valid), .o_data_sel_0(o_data_sel_0),
    .o_random_0(o_random_0), .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass),
    .o_state(o_state)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] obs();
    return {o_state, o_enable, o_valid, o_data_sel_0, o_random_0, o_busy, o_done, o_pass};
  endfunction

  // Expected output word for a state, derived from the output table.
  function automatic logic [14:0] ev(input int st, input bit done, input bit pass);
    logic en, rnd, busy;
    logic [2:0] vld;
    logic [3:0] sel;
    en   = (st >= 2 && st <= 4);
    vld  = en ? 3'b111 : 3'b000;
    sel  = (st == 2) ? 4'b0001 : 4'b0000;
    rnd  = (st == 4);
    busy = (st >= 1 && st <= 6);
    return {3'(st), en, vld, sel, rnd, busy, done, pass};
  endfunction

  task automatic push_run();
    for (int i = 0; i < 4;  i++) sb.push_back(ev(1, 0, 0));
    for (int i = 0; i < 16; i++) sb.push_back(ev(2, 0, 0));
    for (int i = 0; i < 16; i++) sb.push_back(ev(3, 0, 0));
    for (int i = 0; i < 16; i++) sb.push_back(ev(4, 0, 0));
    for (int i = 0; i < 8;  i++) sb.push_back(ev(5, 0, 0));
    sb.push_back(ev(6, 0, 0));
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Drive a one-cycle start; afterwards the first run cycle is under observation.
  task automatic kick();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    push_run();
  endtask

  // Compare n scoreboard entries, one per cycle, advancing a cycle after each.
  task automatic run_phase(input int n, input string name);
    logic [14:0] e;
    for (int i = 0; i < n; i++) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL %s: scoreboard empty at step %0d", name, i);
      end else begin
        e = sb.pop_front();
        if (obs() !== e) begin
          bad++;
          $display("FAIL %s step %0d: got %h want %h", name, i, obs(), e);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (obs() !== 15'd0) begin bad++; $display("FAIL reset_async: got %h want 0", obs()); end
    tick(); tick();
    i_rst = 1'b0;
    tick(); tick();
    total++;
    if (obs() !== ev(0, 0, 0)) begin bad++; $display("FAIL reset_idle: got %h want %h", obs(), ev(0,0,0)); end
  endtask

  task automatic test_pass_run();
    i_block_count = 32'd400; i_data_count = 32'd100; i_ctrl_count = 32'd200; i_inv_block_count = 32'd7;
    kick();
    run_phase(4, "pass_settle");
    i_data_count += 32'd10; i_ctrl_count += 32'd20; i_block_count += 32'd30;
    run_phase(57, "pass_traffic");
    total++;
    if (obs() !== ev(7, 1, 1)) begin bad++; $display("FAIL pass_done: got %h want %h", obs(), ev(7,1,1)); end
  endtask

  task automatic test_fail_inv();
    kick();  // start from DONE
    total++;
    if (o_done !== 1'b0 || o_pass !== 1'b0) begin bad++; $display("FAIL restart_clear: done=%b pass=%b want 0 0", o_done, o_pass); end
    run_phase(4, "inv_settle");
    i_data_count += 32'd10; i_ctrl_count += 32'd20; i_block_count += 32'd30;
    run_phase(32, "inv_data_ctrl");
    i_inv_block_count += 32'd1;
    run_phase(25, "inv_rand");
    total++;
    if (obs() !== ev(7, 1, 0)) begin bad++; $display("FAIL inv_done: got %h want %h", obs(), ev(7,1,0)); end
  endtask

  task automatic test_wrap();
    i_block_count = 32'hFFFFFFF0; i_data_count = 32'hFFFFFFF8; i_ctrl_count = 32'hFFFFFFF8; i_inv_block_count = 32'd5;
    kick();
    run_phase(4, "wrap_settle");
    i_block_count = 32'h10; i_data_count = 32'h08; i_ctrl_count = 32'h08;
    run_phase(57, "wrap_traffic");
    total++;
    if (obs() !== ev(7, 1, 1)) begin bad++; $display("FAIL wrap_done: got %h want %h", obs(), ev(7,1,1)); end
  endtask

  task automatic test_abort();
    kick();
    run_phase(24, "abort_pre");  // now observing the 5th CTRL cycle
    i_abort = 1'b1; i_start = 1'b1;
    tick();
    i_abort = 1'b0; i_start = 1'b0;
    sb.delete();
    total++;
    if (obs() !== ev(0, 0, 0)) begin bad++; $display("FAIL abort_idle: got %h want %h", obs(), ev(0,0,0)); end
    i_abort = 1'b1;
    tick(); tick();
    i_abort = 1'b0;
    total++;
    if (obs() !== ev(0, 0, 0)) begin bad++; $display("FAIL abort_in_idle: got %h want %h", obs(), ev(0,0,0)); end
  endtask

  task automatic test_rst_mid();
    kick();
    run_phase(6, "rst_pre");  // now observing the 3rd DATA cycle
    #2 i_rst = 1'b1;
    #1;
    total++;
    if (obs() !== 15'd0) begin bad++; $display("FAIL rst_mid_async: got %h want 0", obs()); end
    sb.delete();
    tick();
    i_rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    total++;
    if (obs() !== ev(0, 0, 0)) begin bad++; $display("FAIL rst_mid_stay_idle: got %h want %h", obs(), ev(0,0,0)); end
  endtask

  task automatic test_back_to_back();
    i_block_count = 32'd0; i_data_count = 32'd0; i_ctrl_count = 32'd0; i_inv_block_count = 32'd0;
    kick();
    run_phase(10, "b2b_pre");
    i_start = 1'b1;  // ignored while busy
    run_phase(1, "b2b_start_busy");
    i_start = 1'b0;
    i_data_count = 32'd3; i_ctrl_count = 32'd4; i_block_count = 32'd7;
    run_phase(50, "b2b_rest");
    total++;
    if (obs() !== ev(7, 1, 1)) begin bad++; $display("FAIL b2b_done: got %h want %h", obs(), ev(7,1,1)); end
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    total++;
    if (obs() !== ev(1, 0, 0)) begin bad++; $display("FAIL b2b_restart: got %h want %h", obs(), ev(1,0,0)); end
  endtask

  initial begin
    test_reset();
    test_pass_run();
    test_fail_inv();
    test_wrap();
    test_abort();
    test_rst_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/baser_test_sequencer.md
BASER_TEST_SEQUENCER -- requirements
Module: baser_test_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_LEN, default 4: idle cycles after start before traffic (>=1).
REQ-002 SHALL have parameter PHASE_LEN, default 16: cycles spent in each traffic phase (>=1).
REQ-003 SHALL have parameter DRAIN_LEN, default 8: idle cycles after traffic, letting the generator/checker pipeline empty (>=1).
REQ-004 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port i_start  in  1  run request, sampled per cycle.
REQ-007 SHALL have port i_abort  in  1  cancel request, sampled per cycle.
REQ-008 SHALL have ports i_block_count, i_data_count, i_ctrl_count, i_inv_block_count  in  32 each  live checker counters.
REQ-009 SHALL have port o_enable  out  1  generator frame-enable.
REQ-010 SHALL have port o_valid  out  3  generator valid.
REQ-011 SHALL have port o_data_sel_0  out  4  generator lane-0 data selector.
REQ-012 SHALL have port o_random_0  out  1  generator lane-0 random mode.
REQ-013 SHALL have ports o_busy, o_done, o_pass  out  1 each  run status.
REQ-014 SHALL have port o_state  out  3  current state encoding.

Function
REQ-015 SHALL implement states IDLE=0, SETTLE=1, DATA=2, CTRL=3, RAND=4, DRAIN=5, CHECK=6, DONE=7, reported on o_state.
REQ-016 SHALL drive generator outputs registered, changing on the same edge as o_state:
- IDLE/SETTLE/DRAIN/CHECK/DONE: enable 0, valid 3'b000, sel 4'b0000, random 0
- DATA: enable 1, valid 3'b111, sel 4'b0001, random 0
- CTRL: enable 1, valid 3'b111, sel 4'b0000, random 0
- RAND: enable 1, valid 3'b111, sel 4'b0000, random 1
REQ-017 SHALL leave IDLE for SETTLE on i_start=1; IDLE persists otherwise.
REQ-018 SHALL use one down-counter; SETTLE lasts exactly SETTLE_LEN cycles, each of DATA/CTRL/RAND exactly PHASE_LEN, DRAIN exactly DRAIN_LEN; the counter reloads on every state entry.
REQ-019 SHALL sequence SETTLE->DATA->CTRL->RAND->DRAIN->CHECK->DONE; CHECK lasts exactly 1 cycle.
REQ-020 SHALL snapshot all four counter inputs on the edge entering DATA.
REQ-021 SHALL compute deltas in CHECK as 32-bit modulo (current - snapshot), so counter wrap-around past 2^32-1 yields the correct delta.
REQ-022 SHALL register o_pass=1 on the CHECK->DONE edge iff inv delta==0, data delta!=0, ctrl delta!=0 and block delta==data delta+ctrl delta (32-bit modulo sum); else o_pass=0.
REQ-023 SHALL hold o_done=1 and o_pass stable in DONE; i_start in DONE clears o_done/o_pass and enters SETTLE on the next edge.
REQ-024 SHALL drive o_busy=1 in SETTLE..CHECK, 0 in IDLE and DONE.
REQ-025 SHALL ignore i_start while o_busy=1.
REQ-026 SHALL, on i_abort=1 in any busy state, enter IDLE next edge with generator outputs idle, o_done=0 and o_pass=0; i_abort has priority over i_start and over counter expiry in the same cycle; i_abort in IDLE/DONE is ignored.
REQ-027 SHALL total 1 run = SETTLE_LEN + 3*PHASE_LEN + DRAIN_LEN + 1 cycles from the edge entering SETTLE to the edge entering DONE.

Reset
REQ-028 SHALL, while i_rst=1, asynchronously force state IDLE, counter 0, snapshots 0, o_enable=0, o_valid=0, o_data_sel_0=0, o_random_0=0, o_busy=0, o_done=0, o_pass=0, o_state=0.
REQ-029 SHALL abandon a run when reset asserts mid-operation, leaving IDLE after release only on a fresh i_start.

Verification
REQ-030 Defaults, counters advancing inv+0/data+10/ctrl+20/block+30, 1-cycle i_start -> SETTLE 4, DATA 16 (sel 0001), CTRL 16, RAND 16 (random 1), DRAIN 8, CHECK 1; o_done=1, o_pass=1 after 61 cycles.
REQ-031 Same run, i_inv_block_count +1 during RAND -> o_done=1, o_pass=0.
REQ-032 Snapshot block=0xFFFFFFF0, data=0xFFFFFFF8, ctrl=0xFFFFFFF8, inv=5; at CHECK block=0x10, data=0x08, ctrl=0x08, inv=5 -> deltas 32/16/16/0, o_pass=1.
REQ-033 i_abort and i_start together in the 5th CTRL cycle -> next edge o_state=0, o_enable=0, o_valid=000, o_busy=0, o_done=0.
REQ-034 i_rst pulsed in the 3rd DATA cycle -> all outputs 0 immediately (asynchronously); no activity until i_start after release.
REQ-035 i_start repeated during DATA, then in DONE -> first ignored (run length unchanged); second clears o_done/o_pass and enters SETTLE next edge.
